// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for the BCD countdown/count-up timer.
//   - state_e      : FSM state encoding, also driven out on the state port
//   - BCD_DIGIT_W  : bits per BCD digit
//   - FIELD_W      : bits per two-digit BCD field
//   - bcd_clamp()  : forces an out-of-range or non-BCD field to its maximum
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int FIELD_W     = 8;

  // Both digits must be 0..9 and the field must not exceed its maximum.
  // For valid BCD, ordinary binary comparison orders values correctly.
  function automatic logic [FIELD_W-1:0] bcd_clamp(
    input logic [FIELD_W-1:0] value,
    input logic [FIELD_W-1:0] max
  );
    logic bad;
    bad = (value[FIELD_W-1:BCD_DIGIT_W] > 4'd9) ||
          (value[BCD_DIGIT_W-1:0] > 4'd9) ||
          (value > max);
    return bad ? max : value;
  endfunction

endpackage

// File: rtl/timer_bcd_field.sv
// timer_bcd_field
//   Combinational single-field BCD step (two digits, modulus max_i+1).
//   Ports:
//     value_i      : current packed BCD field value
//     max_i        : packed BCD maximum of this field
//     dir_i        : 1 = count up, 0 = count down
//     step_in_i    : apply a step to this field
//     next_value_o : field value after the step
//     step_out_o   : wrap (up) or borrow (down) into the next field
module timer_bcd_field
  import timer_pkg::*;
(
  input  logic [FIELD_W-1:0] value_i,
  input  logic [FIELD_W-1:0] max_i,
  input  logic               dir_i,
  input  logic               step_in_i,
  output logic [FIELD_W-1:0] next_value_o,
  output logic               step_out_o
);

  logic [BCD_DIGIT_W-1:0] hi;
  logic [BCD_DIGIT_W-1:0] lo;
  logic [BCD_DIGIT_W-1:0] hi_inc;
  logic [BCD_DIGIT_W-1:0] hi_dec;
  logic [BCD_DIGIT_W-1:0] lo_inc;
  logic [BCD_DIGIT_W-1:0] lo_dec;

  assign hi     = value_i[FIELD_W-1:BCD_DIGIT_W];
  assign lo     = value_i[BCD_DIGIT_W-1:0];
  assign hi_inc = hi + 4'd1;
  assign hi_dec = hi - 4'd1;
  assign lo_inc = lo + 4'd1;
  assign lo_dec = lo - 4'd1;

  always_comb begin
    next_value_o = value_i;
    step_out_o   = 1'b0;
    if (step_in_i) begin
      if (dir_i) begin
        // >= rather than == keeps the field bounded even if it ever held
        // a value above its maximum.
        if (value_i >= max_i) begin
          next_value_o = '0;
          step_out_o   = 1'b1;
        end else if (lo == 4'd9) begin
          next_value_o = {hi_inc, 4'd0};
        end else begin
          next_value_o = {hi, lo_inc};
        end
      end else begin
        if (value_i == '0) begin
          next_value_o = max_i;
          step_out_o   = 1'b1;
        end else if (lo == 4'd0) begin
          next_value_o = {hi_dec, 4'd9};
        end else begin
          next_value_o = {hi, lo_dec};
        end
      end
    end
  end

endmodule

// File: rtl/timer_bcd_chain.sv
// timer_bcd_chain
//   Multi-field BCD countdown/count-up timer with built-in prescaler,
//   run/pause/done FSM, load clamping and per-field carry/borrow pulses.
//   Ports:
//     Clk        : system clock (rising edge)
//     reset      : asynchronous active-low reset
//     load       : load clamped init_value, go IDLE, clear prescaler
//     start      : run (from IDLE) or resume (from PAUSED)
//     pause      : RUN -> PAUSED, prescaler phase kept
//     stop       : go IDLE, clear prescaler, keep count
//     up_down    : 1 = up, 0 = down, used at each tick
//     init_value : packed BCD load value
//     count      : current packed BCD count (registered)
//     state      : FSM state, IDLE=0 RUN=1 PAUSED=2 DONE=3 (registered)
//     tick       : high in the cycle a count step is taken
//     carry      : per-field wrap/borrow pulse, aligned with the new count
//     done       : pulse when a down count reaches zero
//   Command priority: load > stop > pause > start. A command that is
//   ignored in the current state does not block a lower-priority one.
module timer_bcd_chain
  import timer_pkg::*;
#(
  parameter int                        NUM_FIELDS = 3,
  parameter logic [8*NUM_FIELDS-1:0]   FIELD_MAX  = 24'h23_59_59,
  parameter int                        TICK_DIV   = 50_000_000
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         stop,
  input  logic                         up_down,
  input  logic [8*NUM_FIELDS-1:0]      init_value,
  output logic [8*NUM_FIELDS-1:0]      count,
  output logic [1:0]                   state,
  output logic                         tick,
  output logic [NUM_FIELDS-1:0]        carry,
  output logic                         done
);

  localparam int CW = FIELD_W * NUM_FIELDS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NUM_FIELDS-1:0] carry_q, carry_d;
  logic                  done_q, done_d;

  logic                  tick_w;
  logic [CW-1:0]         clamped;
  logic [CW-1:0]         step_count;
  logic [NUM_FIELDS:0]   step_chain;

  logic                  pause_ok;
  logic                  start_ok;
  logic                  start_to_done;
  logic                  step_to_zero;

  // ---------------------------------------------------------------------
  // Field step chain: the ripple is purely combinational, so a full-width
  // wrap or borrow resolves in the tick cycle itself.
  // ---------------------------------------------------------------------
  assign step_chain[0] = 1'b1;

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    timer_bcd_field u_field (
      .value_i      (count_q[g*FIELD_W +: FIELD_W]),
      .max_i        (FIELD_MAX[g*FIELD_W +: FIELD_W]),
      .dir_i        (up_down),
      .step_in_i    (step_chain[g]),
      .next_value_o (step_count[g*FIELD_W +: FIELD_W]),
      .step_out_o   (step_chain[g+1])
    );
  end

  always_comb begin
    clamped = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      clamped[i*FIELD_W +: FIELD_W] =
        bcd_clamp(init_value[i*FIELD_W +: FIELD_W], FIELD_MAX[i*FIELD_W +: FIELD_W]);
    end
  end

  // ---------------------------------------------------------------------
  // Command decode shared by the FSM and the datapath
  // ---------------------------------------------------------------------
  assign tick_w        = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
  assign pause_ok      = pause && (state_q == ST_RUN);
  assign start_ok      = start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED));
  // Starting a down count from zero finishes at once without a tick.
  assign start_to_done = (count_q == '0) && !up_down;
  assign step_to_zero  = !up_down && (step_count == '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (load || stop) begin
      state_d = ST_IDLE;
    end else if (pause_ok) begin
      state_d = ST_PAUSED;
    end else if (start_ok) begin
      state_d = start_to_done ? ST_DONE : ST_RUN;
    end else if (tick_w && step_to_zero) begin
      state_d = ST_DONE;
    end
  end

  // FSM: outputs (all registered except tick)
  assign state = state_q;
  assign tick  = tick_w;
  assign count = count_q;
  assign carry = carry_q;
  assign done  = done_q;

  // ---------------------------------------------------------------------
  // Datapath: prescaler, count, carry and done pulses
  // ---------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    carry_d = '0;
    done_d  = 1'b0;
    if (load) begin
      count_d = clamped;
      presc_d = '0;
    end else if (stop) begin
      presc_d = '0;
    end else if (pause_ok) begin
      presc_d = presc_q;
    end else if (start_ok) begin
      if (start_to_done) begin
        done_d = 1'b1;
      end else if (state_q == ST_IDLE) begin
        presc_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      if (tick_w) begin
        presc_d = '0;
        count_d = step_count;
        if (step_to_zero) begin
          done_d = 1'b1;
        end else begin
          carry_d = step_chain[NUM_FIELDS:1];
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      count_q <= '0;
      carry_q <= '0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_timer_bcd_chain.sv
// tb_timer_bcd_chain
//   Bench for timer_bcd_chain (NUM_FIELDS=3, FIELD_MAX=23_59_59, TICK_DIV=4).
//   The reference model keeps the count as one mixed-radix integer and
//   derives wraps/borrows from divisibility by the field radix products.
module tb_timer_bcd_chain;

  localparam int          NF   = 3;
  localparam logic [23:0] FMAX = 24'h23_59_59;
  localparam int          TD   = 4;

  // -------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------
  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        up_down = 1'b0;
  logic [23:0] init_value = '0;
  logic [23:0] count;
  logic [1:0]  state;
  logic        tick;
  logic [2:0]  carry;
  logic        done;

  always #5 Clk = ~Clk;

  timer_bcd_chain #(
    .NUM_FIELDS (NF),
    .FIELD_MAX  (FMAX),
    .TICK_DIV   (TD)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .up_down    (up_down),
    .init_value (init_value),
    .count      (count),
    .state      (state),
    .tick       (tick),
    .carry      (carry),
    .done       (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Reference model helpers
  // -------------------------------------------------------------------
  function automatic int radix_of(input int i);
    logic [23:0] fm;
    logic [7:0]  f;
    fm = FMAX;
    f  = fm[8*i +: 8];
    return int'(f[7:4]) * 10 + int'(f[3:0]) + 1;
  endfunction

  function automatic int pfx_of(input int i);
    int p = 1;
    for (int j = 0; j <= i; j++) p = p * radix_of(j);
    return p;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int f;
    r = '0;
    for (int i = 0; i < NF; i++) begin
      f = v % radix_of(i);
      v = v / radix_of(i);
      r[8*i +: 8] = {4'(f / 10), 4'(f % 10)};
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [23:0] iv);
    int v = 0;
    int hi, lo, d, mx;
    for (int i = NF - 1; i >= 0; i--) begin
      hi = int'(iv[8*i+4 +: 4]);
      lo = int'(iv[8*i +: 4]);
      d  = hi * 10 + lo;
      mx = radix_of(i) - 1;
      if (hi > 9 || lo > 9 || d > mx) d = mx;
      v = v * radix_of(i) + d;
    end
    return v;
  endfunction

  // Model state: 0 idle, 1 run, 2 paused, 3 done
  int         m_state = 0;
  int         m_presc = 0;
  int         m_val   = 0;
  logic [2:0] m_carry = '0;
  logic       m_done  = 1'b0;

  always @(posedge Clk or negedge reset) begin : model
    int total;
    logic [2:0] c;
    logic d;
    if (!reset) begin
      m_state = 0;
      m_presc = 0;
      m_val   = 0;
      m_carry = '0;
      m_done  = 1'b0;
    end else begin
      total = pfx_of(NF - 1);
      c = '0;
      d = 1'b0;
      if (load) begin
        m_val = clamp_val(init_value);
        m_state = 0;
        m_presc = 0;
      end else if (stop) begin
        m_state = 0;
        m_presc = 0;
      end else if (pause && m_state == 1) begin
        m_state = 2;
      end else if (start && (m_state == 0 || m_state == 2)) begin
        if (m_val == 0 && !up_down) begin
          m_state = 3;
          d = 1'b1;
        end else begin
          if (m_state == 0) m_presc = 0;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          if (up_down) begin
            for (int i = 0; i < NF; i++) c[i] = ((m_val + 1) % pfx_of(i)) == 0;
            m_val = (m_val + 1) % total;
          end else begin
            for (int i = 0; i < NF; i++) c[i] = (m_val % pfx_of(i)) == 0;
            m_val = (m_val - 1 + total) % total;
            if (m_val == 0) begin
              m_state = 3;
              d = 1'b1;
              c = '0;
            end
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
      m_carry = c;
      m_done  = d;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (reset) begin
      chk("count", 32'(count), 32'(to_bcd(m_val)));
      chk("state", 32'(state), 32'(m_state));
      chk("tick",  32'(tick),  32'(m_state == 1 && m_presc == TD - 1));
      chk("carry", 32'(carry), 32'(m_carry));
      chk("done",  32'(done),  32'(m_done));
    end
  end

  // -------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------
  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_load(input logic [23:0] v);
    init_value = v;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Waits for a tick cycle, then steps past it so the updated count shows.
  task automatic wait_tick(input int bound, output int waited);
    waited = 0;
    while (tick !== 1'b1 && waited < bound) begin
      cyc();
      waited++;
    end
    if (tick !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: got no tick expected tick within %0d cycles", bound);
    end
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------
  initial begin : stim
    int w;
    int ntk;
    logic [23:0] held;
    int r;

    reset = 1'b0;
    repeat (3) cyc();
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick",  32'(tick),  32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    reset = 1'b1;
    cyc();

    // Up roll across all fields
    up_down = 1'b1;
    do_load(24'h23_59_58);
    chk("up_load", 32'(count), 32'h23_59_58);
    do_start();
    chk("up_state", 32'(state), 32'd1);
    wait_tick(8, w);
    chk("up_first_wait", 32'(w), 32'd3);
    chk("up_step1", 32'(count), 32'h23_59_59);
    chk("up_step1_carry", 32'(carry), 32'd0);
    wait_tick(8, w);
    chk("up_period", 32'(w), 32'd3);
    chk("up_roll", 32'(count), 32'h00_00_00);
    chk("up_roll_carry", 32'(carry), 32'b111);
    chk("up_roll_state", 32'(state), 32'd1);
    cyc();
    chk("up_carry_clear", 32'(carry), 32'd0);

    // Asynchronous reset in the middle of a run
    do_load(24'h12_34_56);
    do_start();
    repeat (2) cyc();
    chk("ar_run", 32'(state), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'h0);
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_carry", 32'(carry), 32'd0);
    chk("ar_done",  32'(done),  32'd0);
    #1;
    reset = 1'b1;
    cyc();

    // Down count to done
    up_down = 1'b0;
    do_load(24'h00_01_01);
    do_start();
    wait_tick(8, w);
    chk("dn_step1", 32'(count), 32'h00_01_00);
    chk("dn_step1_carry", 32'(carry), 32'd0);
    wait_tick(8, w);
    chk("dn_borrow", 32'(count), 32'h00_00_59);
    chk("dn_borrow_carry", 32'(carry), 32'b001);
    for (int i = 0; i < 59; i++) wait_tick(8, w);
    chk("dn_zero", 32'(count), 32'h0);
    chk("dn_done", 32'(done), 32'd1);
    chk("dn_state", 32'(state), 32'd3);
    chk("dn_carry", 32'(carry), 32'd0);
    cyc();
    chk("dn_done_clear", 32'(done), 32'd0);
    ntk = 0;
    repeat (12) begin
      if (tick) ntk++;
      cyc();
    end
    chk("dn_no_ticks", 32'(ntk), 32'd0);
    chk("dn_held_state", 32'(state), 32'd3);

    // Pause / resume keeps the prescaler phase
    up_down = 1'b1;
    do_load(24'h00_00_10);
    do_start();
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pa_state", 32'(state), 32'd2);
    held = count;
    ntk = 0;
    repeat (10) begin
      if (tick) ntk++;
      if (count !== held) ntk += 100;
      cyc();
    end
    chk("pa_static", 32'(ntk), 32'd0);
    chk("pa_count", 32'(count), 32'h00_00_10);
    do_start();
    chk("pa_resume_state", 32'(state), 32'd1);
    chk("pa_resume_tick0", 32'(tick), 32'd0);
    cyc();
    chk("pa_resume_tick1", 32'(tick), 32'd1);
    cyc();
    chk("pa_step", 32'(count), 32'h00_00_11);

    // Load clamp
    do_load(24'h25_7A_42);
    chk("cl_count", 32'(count), 32'h23_59_42);
    chk("cl_state", 32'(state), 32'd0);

    // Simultaneous commands, then zero start
    init_value = 24'h00_00_05;
    load = 1'b1;
    stop = 1'b1;
    start = 1'b1;
    cyc();
    load = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    chk("sim_state", 32'(state), 32'd0);
    chk("sim_count", 32'(count), 32'h00_00_05);
    up_down = 1'b0;
    do_load(24'h0);
    do_start();
    chk("zs_state", 32'(state), 32'd3);
    chk("zs_done",  32'(done),  32'd1);
    chk("zs_tick",  32'(tick),  32'd0);
    cyc();
    chk("zs_done_clear", 32'(done), 32'd0);

    // Randomised commands checked by the every-cycle model compare
    repeat (900) begin
      r = $urandom_range(0, 99);
      load  = (r < 3);
      stop  = (r >= 3 && r < 5);
      pause = (r >= 5 && r < 8) || ($urandom_range(0, 99) < 2);
      start = (r >= 8 && r < 20) || ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 6) up_down = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       init_value = 24'($urandom);
        1:       init_value = {16'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        default: init_value = to_bcd($urandom_range(0, pfx_of(NF - 1) - 1));
      endcase
      cyc();
    end
    load = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    start = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
